tanh_batch_ctrl: RTL and testbench

- Batch sequencer that drives the tanh unit over a block of samples.
- Reads 20-bit sign-magnitude operands from an input memory and presents each one as `ai`.
- Pulses `start_tanh` and `start_interpolation` at fixed cycle offsets, then captures the 16-bit saturated result and writes it to the output memory at the sample's index.
- Sits between the host/input buffer and the output buffer; the tanh unit's only operand source and result consumer.

---
 rtl/tanh_batch_ctrl.sv | 144 ++++++++++++++
 tb/tb_tanh_batch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tanh_batch_ctrl.sv
// Batch sequencer feeding the tanh unit: fetch operand, pulse start_tanh / start_interpolation, write result.
// Optional saturated-result counter is built only when TANH_SAT_COUNT_EN is defined.
module tanh_batch_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int LUT_WAIT    = 2,
  parameter int INTERP_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [19:0]       rd_data,
  output logic [19:0]       ai,
  output logic              start_tanh,
  output logic              start_interpolation,
  input  logic [15:0]       result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] sat_count,
  output logic [3:0]        dbg_state
);

  // Handshake: go is a level sampled only in IDLE; every other output is a Moore
  // decode of the state register except wr_data, which forwards result during WRITE.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LOAD   = 4'd2,
    S_TANH   = 4'd3,
    S_WAIT_L = 4'd4,
    S_INTERP = 4'd5,
    S_WAIT_I = 4'd6,
    S_WRITE  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam int WAIT_W = 16;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [15:0]         r_wr_data;
  logic [19:0]         r_ai;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_go_acc;
  logic                w_last;

  assign w_go_acc = (r_state == S_IDLE) && go;
  assign w_last   = (r_idx == r_cnt - 1'b1);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (go) w_next = (count == '0) ? S_DONE : S_FETCH;
      S_FETCH:  w_next = S_LOAD;
      S_LOAD:   w_next = S_TANH;
      S_TANH:   w_next = S_WAIT_L;
      S_WAIT_L: if (r_wait == '0) w_next = S_INTERP;
      S_INTERP: w_next = S_WAIT_I;
      S_WAIT_I: if (r_wait == '0) w_next = S_WRITE;
      S_WRITE:  w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // rd_addr is set on entry to FETCH so the synchronous memory returns data during LOAD.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ai      <= '0;
      r_wait    <= '0;
    end else begin
      if (w_go_acc) begin
        r_cnt <= count;
        r_idx <= '0;
        if (count != '0) r_rd_addr <= '0;
      end
      case (r_state)
        S_LOAD:   r_ai   <= rd_data;
        S_TANH:   r_wait <= WAIT_W'(LUT_WAIT - 1);
        S_INTERP: r_wait <= WAIT_W'(INTERP_WAIT - 1);
        S_WAIT_L: if (r_wait != '0) r_wait <= r_wait - 1'b1;
        S_WAIT_I: begin
          if (r_wait != '0) r_wait    <= r_wait - 1'b1;
          else              r_wr_addr <= r_idx;
        end
        S_WRITE: begin
          r_wr_data <= result;
          if (!w_last) begin
            r_idx     <= r_idx + 1'b1;
            r_rd_addr <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy                = (r_state != S_IDLE);
  assign done                = (r_state == S_DONE);
  assign start_tanh          = (r_state == S_TANH);
  assign start_interpolation = (r_state == S_INTERP);
  assign wr_en               = (r_state == S_WRITE);
  assign wr_addr             = r_wr_addr;
  assign wr_data             = wr_en ? result : r_wr_data;
  assign rd_addr             = r_rd_addr;
  assign ai                  = r_ai;
  assign dbg_state           = r_state;

`ifdef TANH_SAT_COUNT_EN
  logic [ADDR_W-1:0] r_sat;
  logic              w_is_sat;

  assign w_is_sat = (result == 16'h7FFF) || (result == 16'h8000);

  always_ff @(posedge clock) begin
    if (!reset_n)                              r_sat <= '0;
    else if (w_go_acc)                         r_sat <= '0;
    else if (wr_en && w_is_sat && r_sat != '1) r_sat <= r_sat + 1'b1;
  end

  assign sat_count = r_sat;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_tanh_batch_ctrl.sv
// Directed bench for tanh_batch_ctrl: vector table of batches plus a mid-batch reset sequence.
module tb_tanh_batch_ctrl;

  localparam int ADDR_W = 12;
  localparam int PER    = 5 + 2 + 3;
`ifdef TANH_SAT_COUNT_EN
  localparam int SAT_EXP = 2;
`else
  localparam int SAT_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic [ADDR_W-1:0] count;
  logic              busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [19:0]       rd_data;
  logic [19:0]       ai;
  logic              start_tanh, start_interpolation;
  logic [15:0]       result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] sat_count;
  logic [3:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;

  logic [19:0] mem[16];
  logic [15:0] sat_tab[4];
  logic [27:0] exp_q[$];

  tanh_batch_ctrl #(.ADDR_W(ADDR_W), .LUT_WAIT(2), .INTERP_WAIT(3)) dut (
    .clock(clk), .reset_n(rst_n), .go(go), .count(count), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .ai(ai), .start_tanh(start_tanh),
    .start_interpolation(start_interpolation), .result(result), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .sat_count(sat_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous input memory and a tanh stub whose output depends on the operand.
  always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

  always @* begin
    case (mode)
      0:       result = 16'h0100 + ai[15:0];
      1:       result = sat_tab[ai[1:0]];
      default: result = 16'h0000;
    endcase
  end

  typedef struct {
    int cnt;
    int mode;
    int go_again;
    int exp_done;
    int exp_tanh;
    int exp_interp;
    int exp_first_wr;
    int exp_sat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_result(input int m, input int k);
    case (m)
      0:       return 16'h0100 + 16'(k);
      1:       return sat_tab[k];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int cyc, first_t, first_i, nwr, ndone, done_c, clash;
    logic busy_after;
    logic [27:0] got;
    logic [27:0] exp_w;
    string tag;
    tag = $sformatf("v%0d", id);
    mode = v.mode;
    exp_q.delete();
    for (int k = 0; k < v.cnt; k++) exp_q.push_back({ADDR_W'(k), exp_result(v.mode, k)});
    count = ADDR_W'(v.cnt);
    go = 1'b1;
    @(posedge clk);
    cyc = 0; first_t = -1; first_i = -1; nwr = 0; ndone = 0; done_c = -1; clash = 0;
    busy_after = 1'bx;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check({tag, "_sat_clr"}, 32'(sat_count), 32'd0);
      end
      if (start_tanh && first_t < 0) first_t = cyc;
      if (start_interpolation && first_i < 0) first_i = cyc;
      if (start_tanh && start_interpolation) clash++;
      if (wr_en && (start_tanh || start_interpolation)) clash++;
      if (wr_en) begin
        got = {wr_addr, wr_data};
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
        check({tag, "_wr"}, 32'(got), 32'(exp_w));
        check({tag, "_wr_cyc"}, 32'(cyc), 32'(v.exp_first_wr + nwr * PER));
        check({tag, "_ai"}, 32'(ai), 32'(20'hA0000 | 20'(nwr)));
        nwr++;
      end
      if (done) begin
        ndone++;
        done_c = cyc;
      end
      go = (cyc == v.go_again) ? 1'b1 : 1'b0;
      if (cyc == 1) count = ADDR_W'(v.cnt + 5);
      if (done_c >= 0 && cyc == done_c + 1) begin
        busy_after = busy;
        break;
      end
    end
    go = 1'b0;
    check({tag, "_nwr"}, 32'(nwr), 32'(v.cnt));
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_c), 32'(v.exp_done));
    check({tag, "_tanh_cyc"}, 32'(first_t), 32'(v.exp_tanh));
    check({tag, "_interp_cyc"}, 32'(first_i), 32'(v.exp_interp));
    check({tag, "_busy_after"}, 32'(busy_after), 32'd0);
    check({tag, "_pulse_clash"}, 32'(clash), 32'd0);
    check({tag, "_sat"}, 32'(sat_count), 32'(v.exp_sat));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_st"}, 32'(start_tanh), 32'd0);
    check({tag, "_si"}, 32'(start_interpolation), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_ai"}, 32'(ai), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_sat"}, 32'(sat_count), 32'd0);
  endtask

  initial begin
    int nwr_after, ndone_after;
    for (int i = 0; i < 16; i++) mem[i] = 20'hA0000 | 20'(i);
    sat_tab[0] = 16'h7FFF; sat_tab[1] = 16'h1234; sat_tab[2] = 16'h8000; sat_tab[3] = 16'h8001;
    //          cnt mode again done tanh interp first_wr sat
    vecs[0] = '{1, 2, -1, 11,  3,  6, 10, 0};
    vecs[1] = '{3, 0, -1, 31,  3,  6, 10, 0};
    vecs[2] = '{0, 0, -1,  1, -1, -1, 10, 0};
    vecs[3] = '{2, 0,  5, 21,  3,  6, 10, 0};
    vecs[4] = '{4, 1, -1, 41,  3,  6, 10, SAT_EXP};
    vecs[5] = '{1, 2, -1, 11,  3,  6, 10, 0};

    rst_n = 1'b0; go = 1'b0; count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort in WAIT_L of sample 1 (cycles 14/15), then watch for stray activity.
    mode = 0; count = ADDR_W'(4); go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      go = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b1;
    nwr_after = 0; ndone_after = 0;
    repeat (60) begin
      @(negedge clk);
      if (wr_en) nwr_after++;
      if (done) ndone_after++;
    end
    check("midrst_no_wr", 32'(nwr_after), 32'd0);
    check("midrst_no_done", 32'(ndone_after), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
